corescore_stream_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one byte-wide AXI-Stream sink (the UART emitter) between NUM_IN corescorecore sources. Each source emits a complete tlast-terminated message. The arbiter locks the grant for the whole message, so characters from different cores never interleave on the serial line. It sits between the corescorecore array and the emitter and has one registered output stage.

---
 rtl/corescore_pkg.sv | 26 ++
 rtl/corescore_rr_pick.sv | 39 +++
 rtl/corescore_stream_arbiter.sv | 146 ++++++++++++++
 tb/tb_corescore_stream_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/corescore_pkg.sv
// Shared arbitration definitions for the corescore stream blocks.
package corescore_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY
  } arb_state_e;

  // Bits needed to hold an index in 0..value-1; legal for value >= 2.
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer, with wrap.
module corescore_rr_pick
  import corescore_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [PTR_W-1:0]  o_idx,
  output logic              o_found
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_IN - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] cand_s;

  // Walk ptr, ptr+1, ... NUM_IN-1, 0, ... and latch the first requester seen.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    cand_s  = i_ptr;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!o_found && i_req[cand_s]) begin
        o_found = 1'b1;
        o_idx   = cand_s;
      end else begin
        o_found = o_found;
      end
      if (cand_s == LAST_IDX) begin
        cand_s = '0;
      end else begin
        cand_s = cand_s + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one byte stream sink between NUM_IN sources,
// with a single registered output stage.
module corescore_stream_arbiter
  import corescore_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [8*NUM_IN-1:0]   i_tdata,
  input  logic [NUM_IN-1:0]     i_tlast,
  input  logic [NUM_IN-1:0]     i_tvalid,
  output logic [NUM_IN-1:0]     o_tready,
  output logic [7:0]            o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [NUM_IN-1:0]     o_grant,
  output logic                  o_busy
);

  localparam int               PTR_W    = clog2_f(NUM_IN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_IN - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] own_q, own_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       out_data_q, out_data_d;

  logic [PTR_W-1:0]  pick_idx_s;
  logic              pick_found_s;
  logic              load_s;
  logic              accept_s;
  logic              own_valid_s;
  logic              own_last_s;
  logic [7:0]        own_data_s;
  logic [NUM_IN-1:0] grant_s;
  logic [NUM_IN-1:0] tready_s;

  corescore_rr_pick #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_pick (
    .i_req   (i_tvalid),
    .i_ptr   (ptr_q),
    .o_idx   (pick_idx_s),
    .o_found (pick_found_s)
  );

  assign own_valid_s = i_tvalid[own_q];
  assign own_last_s  = i_tlast[own_q];
  assign own_data_s  = i_tdata[{own_q, 3'b000} +: 8];

  // The output register can take a new byte when empty or being drained this cycle.
  assign load_s   = !out_valid_q || i_tready;
  assign accept_s = (state_q == ST_BUSY) && own_valid_s && load_s;

  // Owner decode: only the locked source ever sees grant or ready.
  always_comb begin
    grant_s  = '0;
    tready_s = '0;
    if (state_q == ST_BUSY) begin
      grant_s[own_q]  = 1'b1;
      tready_s[own_q] = load_s;
    end else begin
      grant_s  = '0;
      tready_s = '0;
    end
  end

  // Arbitration FSM: lock on a pick, release and advance ptr on the accepted tlast.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_BUSY;
          own_d   = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (accept_s && own_last_s) begin
          state_d = ST_IDLE;
          ptr_d   = (own_q == LAST_IDX) ? '0 : own_q + PTR_ONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        own_d   = '0;
      end
    endcase
  end

  // Output stage: capture accepted beats, drop valid once drained, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = own_data_s;
      out_last_d  = own_last_s;
    end else if (load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign o_tready = tready_s;
  assign o_grant  = grant_s;
  assign o_busy   = (state_q == ST_BUSY);
  assign o_tvalid = out_valid_q;
  assign o_tdata  = out_data_q;
  assign o_tlast  = out_last_q;

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed bench for corescore_stream_arbiter with NUM_IN=4: vector table plus
// hand-written reset, fairness, locking and async-reset sequences.
module tb_corescore_stream_arbiter;

  localparam int NUM_IN = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tlast;
  logic [3:0]  tvalid;
  logic [3:0]  tready_o;
  logic [7:0]  odata;
  logic        olast;
  logic        ovalid;
  logic        itready;
  logic [3:0]  grant;
  logic        busy;

  int n_checks;
  int n_fail;

  // Simple source model: per-source byte counter and message length.
  int         cnt [4];
  int         len [4];
  logic [3:0] en;
  logic [3:0] acc;

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        r;
    logic [3:0]  g;
    logic [3:0]  tr;
    logic        b;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
  } vec_t;

  vec_t       vecs [15];
  logic [7:0] lock_exp [7];
  logic [7:0] seen [$];

  corescore_stream_arbiter #(.NUM_IN(NUM_IN)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_tdata  (tdata),
    .i_tlast  (tlast),
    .i_tvalid (tvalid),
    .o_tready (tready_o),
    .o_tdata  (odata),
    .o_tlast  (olast),
    .o_tvalid (ovalid),
    .i_tready (itready),
    .o_grant  (grant),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < 4; k++) begin
      tvalid[k]       = en[k];
      tdata[8*k +: 8] = {4'(k), 4'(cnt[k])};
      tlast[k]        = (cnt[k] == len[k] - 1);
    end
  endtask

  task automatic to_negedge();
    drive_src();
    @(negedge clk);
    acc = tready_o & tvalid;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) cnt[k] = tlast[k] ? 0 : cnt[k] + 1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 4'b0000;
    itready = 1'b1;
    acc     = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      len[k] = 3;
    end
    drive_src();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //                v        l        d             r     g        tr       b     ov    od     ol
    vecs[0]  = '{4'b0010, 4'b0000, 32'h0000_1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{4'b0010, 4'b0000, 32'h0000_1000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{4'b0010, 4'b0000, 32'h0000_1100, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'h10, 1'b0};
    vecs[3]  = '{4'b0010, 4'b0000, 32'h0000_1200, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[4]  = '{4'b0010, 4'b0000, 32'h0000_1200, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0000, 32'h0000_1200, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[6]  = '{4'b0010, 4'b0010, 32'h0000_1300, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 8'h12, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h13, 1'b1};
    vecs[8]  = '{4'b0100, 4'b0100, 32'h0020_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{4'b0100, 4'b0100, 32'h0020_0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{4'b1010, 4'b1010, 32'h3000_1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h20, 1'b1};
    vecs[11] = '{4'b1010, 4'b1010, 32'h3000_1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{4'b1010, 4'b1010, 32'h3000_1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h30, 1'b1};
    vecs[13] = '{4'b1010, 4'b1010, 32'h3000_1000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h10, 1'b1};

    lock_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21};

    // Reset held with every source requesting.
    rst_n   = 1'b0;
    itready = 1'b1;
    en      = 4'b1111;
    acc     = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      len[k] = 3;
    end
    drive_src();
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_tready", tready_o, 32'h0);
    check("rst_tvalid", ovalid, 32'h0);
    check("rst_tdata", odata, 32'h0);
    check("rst_tlast", olast, 32'h0);
    rst_n = 1'b1;
    to_next();
    to_negedge();
    check("first_grant", grant, 32'h1);
    check("first_tready", tready_o, 32'h1);
    check("first_tvalid", ovalid, 32'h0);
    check("first_busy", busy, 32'h1);
    to_next();

    // Fairness: all four sources stream 3-byte messages.
    for (int j = 0; j < 19; j++) begin
      int msg;
      int pos;
      int own;
      int nxt;
      msg = j / 4;
      pos = j % 4;
      own = msg % 4;
      nxt = (msg + 1) % 4;
      to_negedge();
      if (pos == 3) begin
        check("fair_gap_valid", ovalid, 32'h0);
        check("fair_gap_grant", grant, 32'd1 << nxt);
        check("fair_gap_tready", tready_o, 32'd1 << nxt);
      end else begin
        check("fair_valid", ovalid, 32'h1);
        check("fair_data", odata, own * 16 + pos);
        check("fair_last", olast, (pos == 2) ? 32'h1 : 32'h0);
        check("fair_grant", grant, (pos == 2) ? 32'h0 : (32'd1 << own));
        check("fair_busy", busy, (pos == 2) ? 32'h0 : 32'h1);
      end
      to_next();
    end

    // Packet locking: source 0 stalls mid-message while source 2 waits.
    do_reset();
    len[0] = 5;
    len[2] = 2;
    seen.delete();
    for (int t = 0; t < 14; t++) begin
      en = {1'b0, 1'b1, 1'b0, !(t >= 3 && t <= 6)};
      to_negedge();
      if (t >= 1 && t <= 9) check("lock_grant", grant, 32'h1);
      if (ovalid) seen.push_back(odata);
      to_next();
    end
    check("lock_count", seen.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < seen.size()) check($sformatf("lock_byte%0d", i), seen[i], lock_exp[i]);
    end

    // Vector table: backpressure, then pointer wrap.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tvalid  = vecs[i].v;
      tlast   = vecs[i].l;
      tdata   = vecs[i].d;
      itready = vecs[i].r;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), grant, vecs[i].g);
      check($sformatf("vec%0d_tready", i), tready_o, vecs[i].tr);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].b);
      check($sformatf("vec%0d_tvalid", i), ovalid, vecs[i].ov);
      if (vecs[i].ov) begin
        check($sformatf("vec%0d_tdata", i), odata, vecs[i].od);
        check($sformatf("vec%0d_tlast", i), olast, vecs[i].ol);
      end
      @(posedge clk);
      #1;
    end

    // Async reset mid-message: ptr is 2 here, so source 2 wins first.
    itready = 1'b1;
    en      = 4'b0101;
    len[0]  = 4;
    len[2]  = 4;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    to_negedge();
    to_next();
    to_negedge();
    check("ar_grant", grant, 32'h4);
    to_next();
    to_negedge();
    to_next();
    to_negedge();
    check("ar_pre_valid", ovalid, 32'h1);
    check("ar_pre_data", odata, 32'h21);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", ovalid, 32'h0);
    check("ar_grant_clr", grant, 32'h0);
    check("ar_busy", busy, 32'h0);
    check("ar_tready", tready_o, 32'h0);
    check("ar_data", odata, 32'h0);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    acc = 4'b0000;
    drive_src();
    @(negedge clk);
    rst_n = 1'b1;
    to_next();
    to_negedge();
    check("ar_restart_grant", grant, 32'h1);
    to_next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
